simple_cpu_core: RTL and testbench

- 8-bit accumulator CPU core and the instruction-consuming end of the CPU test interface.
- Each clock it executes one 8-bit instruction presented on `input_ins` and updates `pc` and `accum_value`.
- The test driver compares `{accum_value, pc}` against expected values after every edge.
- Single-cycle execution, carry/zero flags, HALT state, and an optional single-level CALL/RET.

---
 rtl/simple_cpu_core_if.sv | 27 ++
 rtl/simple_cpu_core.sv | 138 +++++++++++++
 tb/tb_simple_cpu_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/simple_cpu_core_if.sv
// Instruction/status bundle between the CPU test driver and simple_cpu_core.
// Handshake semantics: there is no valid/ready pair. The driver owns
// input_ins and must hold a legal instruction in it across every rising
// edge after reset; the core consumes exactly one instruction per edge
// (unless halted) and its registered status outputs describe the state
// after that edge.
interface simple_cpu_core_if;
  logic [7:0] input_ins;
  logic [7:0] pc;
  logic [7:0] accum_value;
  logic       carry;
  logic       zero;
  logic       halted;
  logic       dbg_state;   // raw FSM state: 0 = RUN, 1 = HALT

  // Driver side: presents instructions, observes status
  modport master (
    output input_ins,
    input  pc, accum_value, carry, zero, halted, dbg_state
  );

  // Core side: consumes instructions, drives status
  modport slave (
    input  input_ins,
    output pc, accum_value, carry, zero, halted, dbg_state
  );
endinterface

// File: rtl/simple_cpu_core.sv
// simple_cpu_core: 8-bit single-cycle accumulator CPU with carry/zero flags
// and a HALT state. Optional single-level CALL/RET is built when the macro
// SIMPLE_CPU_CALL_EN is defined; otherwise opcodes D and E behave as NOP.
module simple_cpu_core (
  input  logic               clk,
  input  logic               CLB,
  simple_cpu_core_if.slave   bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_pc;
  logic [7:0]  r_acc;
  logic        r_c;
  logic        r_z;

  logic [7:0]  w_pc_nxt;
  logic [7:0]  w_acc_nxt;
  logic        w_c_nxt;
  logic        w_z_nxt;

  logic [3:0]  w_op;
  logic [3:0]  w_imm;
  logic [7:0]  w_u;
  logic [7:0]  w_s;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_pc_rel;
  logic [8:0]  w_sum;

`ifdef SIMPLE_CPU_CALL_EN
  logic [7:0]  r_ret;
  logic [7:0]  w_ret_nxt;
`endif

  assign w_op     = bus.input_ins[7:4];
  assign w_imm    = bus.input_ins[3:0];
  assign w_u      = {4'h0, w_imm};
  assign w_s      = {{4{w_imm[3]}}, w_imm};
  assign w_pc_inc = r_pc + 8'd1;
  assign w_pc_rel = r_pc + w_s;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_u};

  // FSM state register; reset always returns to RUN
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath decode; HALT holds every register
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
`ifdef SIMPLE_CPU_CALL_EN
    w_ret_nxt   = r_ret;
`endif
    if (r_state == ST_RUN) begin
      w_pc_nxt = w_pc_inc;
      case (w_op)
        4'h1: w_acc_nxt = w_u;
        4'h2: {w_c_nxt, w_acc_nxt} = w_sum;
        4'h3: begin
          w_acc_nxt = r_acc - w_u;
          w_c_nxt   = (r_acc < w_u);
        end
        4'h4: w_acc_nxt = r_acc & w_u;
        4'h5: w_acc_nxt = r_acc | w_u;
        4'h6: w_acc_nxt = r_acc ^ w_u;
        4'h7: begin
          w_c_nxt   = r_acc[7];
          w_acc_nxt = {r_acc[6:0], 1'b0};
        end
        4'h8: begin
          w_c_nxt   = r_acc[0];
          w_acc_nxt = {1'b0, r_acc[7:1]};
        end
        4'h9: w_acc_nxt = {w_imm, r_acc[3:0]};
        4'hA: w_pc_nxt = w_pc_rel;
        4'hB: if (r_z) w_pc_nxt = w_pc_rel;
        4'hC: if (r_c) w_pc_nxt = w_pc_rel;
`ifdef SIMPLE_CPU_CALL_EN
        4'hD: begin
          w_ret_nxt = w_pc_inc;
          w_pc_nxt  = w_pc_rel;
        end
        4'hE: w_pc_nxt = r_ret;
`endif
        4'hF: begin
          // HLT freezes the machine on the current PC
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALT;
        end
        default: ;
      endcase
      // Zero flag tracks only the accumulator-writing opcodes 1..9
      if ((w_op >= 4'h1) && (w_op <= 4'h9)) w_z_nxt = (w_acc_nxt == 8'h00);
    end
  end

  // Architectural registers with asynchronous reset
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_pc  <= 8'h00;
      r_acc <= 8'h00;
      r_c   <= 1'b0;
      r_z   <= 1'b1;
    end else begin
      r_pc  <= w_pc_nxt;
      r_acc <= w_acc_nxt;
      r_c   <= w_c_nxt;
      r_z   <= w_z_nxt;
    end
  end

`ifdef SIMPLE_CPU_CALL_EN
  // Single-level return address; a nested CALL simply overwrites it
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) r_ret <= 8'h00;
    else      r_ret <= w_ret_nxt;
  end
`endif

  assign bus.pc          = r_pc;
  assign bus.accum_value = r_acc;
  assign bus.carry       = r_c;
  assign bus.zero        = r_z;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_simple_cpu_core.sv
// Directed testbench for simple_cpu_core. Expected values are hand-computed
// from the instruction set; the CALL/RET section follows SIMPLE_CPU_CALL_EN.
module tb_simple_cpu_core;

  logic clk;
  logic CLB;
  int   checks;
  int   errors;

  simple_cpu_core_if bus ();

  simple_cpu_core dut (
    .clk (clk),
    .CLB (CLB),
    .bus (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report on mismatch
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full status comparison of {acc, pc} plus flags
  task automatic chk_state(input string tag, input logic [7:0] acc, input logic [7:0] pc,
                           input logic c, input logic z);
    chk({tag, ".acc"}, bus.accum_value, acc);
    chk({tag, ".pc"},  bus.pc, pc);
    chk({tag, ".c"},   {7'd0, bus.carry}, {7'd0, c});
    chk({tag, ".z"},   {7'd0, bus.zero},  {7'd0, z});
  endtask

  // Assert reset away from the clock edge and check the async-cleared values
  task automatic do_reset();
    @(negedge clk);
    CLB = 1'b0;
    bus.input_ins = 8'h00;
    #1;
    chk_state("reset", 8'h00, 8'h00, 1'b0, 1'b1);
    chk("reset.halted", {7'd0, bus.halted}, 8'h00);
    chk("reset.state",  {7'd0, bus.dbg_state}, 8'h00);
  endtask

  // Drive one instruction; release reset together with the first one
  task automatic step(input logic [7:0] ins);
    @(negedge clk);
    CLB = 1'b1;
    bus.input_ins = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    CLB = 1'b0;
    bus.input_ins = 8'h00;

    // LDI / LDH / ADDI without carry
    do_reset();
    step(8'h15); chk_state("s1.ldi",  8'h05, 8'h01, 1'b0, 1'b0);
    step(8'h9F); chk_state("s1.ldh",  8'hF5, 8'h02, 1'b0, 1'b0);
    step(8'h27); chk_state("s1.addi", 8'hFC, 8'h03, 1'b0, 1'b0);

    // ADDI with carry out, then JC taken backwards
    do_reset();
    step(8'h1A);
    step(8'h9F); chk("s2.ldh.acc", bus.accum_value, 8'hFA);
    step(8'h27); chk_state("s2.addi", 8'h01, 8'h03, 1'b1, 1'b0);
    step(8'hCE); chk_state("s2.jc",   8'h01, 8'h01, 1'b1, 1'b0);

    // SUBI to zero, JZ taken
    do_reset();
    step(8'h13);
    step(8'h33); chk_state("s3.subi", 8'h00, 8'h02, 1'b0, 1'b1);
    step(8'hB3); chk_state("s3.jz",   8'h00, 8'h05, 1'b0, 1'b1);

    // SUBI with borrow, JZ not taken
    do_reset();
    step(8'h13);
    step(8'h34); chk_state("s4.subi", 8'hFF, 8'h02, 1'b1, 1'b0);
    step(8'hB3); chk_state("s4.jz",   8'hFF, 8'h03, 1'b1, 1'b0);

    // Logic ops, shifts, and JMP with S = 0
    do_reset();
    step(8'h1C); chk_state("s5.ldi",  8'h0C, 8'h01, 1'b0, 1'b0);
    step(8'h4A); chk_state("s5.andi", 8'h08, 8'h02, 1'b0, 1'b0);
    step(8'h53); chk_state("s5.ori",  8'h0B, 8'h03, 1'b0, 1'b0);
    step(8'h6F); chk_state("s5.xori", 8'h04, 8'h04, 1'b0, 1'b0);
    step(8'h64); chk_state("s5.xorz", 8'h00, 8'h05, 1'b0, 1'b1);
    step(8'h19);
    step(8'h98); chk_state("s5.ldh",  8'h89, 8'h07, 1'b0, 1'b0);
    step(8'h70); chk_state("s5.shl",  8'h12, 8'h08, 1'b1, 1'b0);
    step(8'h80); chk_state("s5.shr1", 8'h09, 8'h09, 1'b0, 1'b0);
    step(8'h80); chk_state("s5.shr2", 8'h04, 8'h0A, 1'b1, 1'b0);
    step(8'h4F); chk_state("s5.andc", 8'h04, 8'h0B, 1'b1, 1'b0);
    step(8'hA0); chk_state("s5.loop1", 8'h04, 8'h0B, 1'b1, 1'b0);
    step(8'hA0); chk_state("s5.loop2", 8'h04, 8'h0B, 1'b1, 1'b0);

    // HALT holds everything; async reset exits it mid-cycle
    do_reset();
    step(8'h15);
    step(8'hF0); chk_state("s6.hlt", 8'h05, 8'h01, 1'b0, 1'b0);
    chk("s6.halted", {7'd0, bus.halted}, 8'h01);
    chk("s6.state",  {7'd0, bus.dbg_state}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step(8'h15);
      chk_state("s6.hold", 8'h05, 8'h01, 1'b0, 1'b0);
      chk("s6.hold.halted", {7'd0, bus.halted}, 8'h01);
    end
    #2;
    CLB = 1'b0;
    #1;
    chk_state("s6.async", 8'h00, 8'h00, 1'b0, 1'b1);
    chk("s6.async.halted", {7'd0, bus.halted}, 8'h00);
    step(8'h12); chk_state("s6.resume", 8'h02, 8'h01, 1'b0, 1'b0);

    // PC wrap through a negative branch at 00 and increment at FF
    do_reset();
    step(8'hAF); chk("s7.jmp.pc", bus.pc, 8'hFF);
    step(8'h00); chk("s7.wrap.pc", bus.pc, 8'h00);

    // CALL / RET
    do_reset();
    step(8'hA4); chk("s8.jmp.pc", bus.pc, 8'h04);
`ifdef SIMPLE_CPU_CALL_EN
    step(8'hD4); chk_state("s8.call", 8'h00, 8'h08, 1'b0, 1'b1);
    step(8'hE0); chk_state("s8.ret",  8'h00, 8'h05, 1'b0, 1'b1);
    do_reset();
    step(8'h00);
    step(8'hE0); chk("s8.ret0.pc", bus.pc, 8'h00);
`else
    step(8'hD4); chk_state("s8.d_nop", 8'h00, 8'h05, 1'b0, 1'b1);
    step(8'hE0); chk_state("s8.e_nop", 8'h00, 8'h06, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
